// File: rtl/router_fsm_if.sv
// Handshake/status bundle between the router FSM and its source, FIFOs and register block.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;
    logic       busy;
    logic       drop_pkt;

    // FSM side
    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output write_enb_reg, busy, drop_pkt
    );

    // Environment side (source, FIFOs, register block)
    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  write_enb_reg, busy, drop_pkt
    );
endinterface

// File: rtl/router_fsm.sv
// Router control FSM: header decode, load sequencing, full stall and per-port soft reset.
// Optional WAIT_TILL_EMPTY abort timer enabled by defining ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input logic        clk,
    input logic        rstn,
    router_fsm_if.slave bus
);

    localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] LOAD_DATA          = 3'd2;
    localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
    localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
    localparam logic [2:0] LOAD_PARITY        = 3'd5;
    localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
    localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("router_fsm: TIMEOUT_CYCLES must be in 2..255");
    end

    logic [2:0] state;
    logic [2:0] next_state;
    logic [1:0] port;
    logic [1:0] next_port;

    logic hdr_empty;
    logic port_empty;
    logic port_soft_reset;
    logic hdr_valid;

    assign hdr_valid = bus.pkt_valid && (bus.data_in != 2'b11);

    always_comb begin
        hdr_empty = 1'b0;
        case (bus.data_in)
            2'd0:    hdr_empty = bus.fifo_empty_0;
            2'd1:    hdr_empty = bus.fifo_empty_1;
            2'd2:    hdr_empty = bus.fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
    end

    always_comb begin
        port_empty      = 1'b0;
        port_soft_reset = 1'b0;
        case (port)
            2'd0: begin
                port_empty      = bus.fifo_empty_0;
                port_soft_reset = bus.soft_reset_0;
            end
            2'd1: begin
                port_empty      = bus.fifo_empty_1;
                port_soft_reset = bus.soft_reset_1;
            end
            2'd2: begin
                port_empty      = bus.fifo_empty_2;
                port_soft_reset = bus.soft_reset_2;
            end
            default: begin
                port_empty      = 1'b0;
                port_soft_reset = 1'b0;
            end
        endcase
    end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       expire;
    logic       drop_q;

    // wait_cnt holds (cycles already spent in WAIT_TILL_EMPTY - 1) during the current cycle
    assign expire = (state == WAIT_TILL_EMPTY) && (wait_cnt == TIMEOUT_LIMIT);
`else
    logic expire;
    assign expire = 1'b0;
`endif

    always_comb begin
        next_state = state;
        next_port  = port;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_valid) begin
                    next_port  = bus.data_in;
                    next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)
                    next_state = FIFO_FULL_STATE;
                else if (!bus.pkt_valid)
                    next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full)
                    next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)
                    next_state = DECODE_ADDRESS;
                else if (bus.low_pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (port_empty)
                    next_state = LOAD_FIRST_DATA;
                else if (expire)
                    next_state = DECODE_ADDRESS;
            end
            default: next_state = DECODE_ADDRESS;
        endcase

        if (state != DECODE_ADDRESS && port_soft_reset)
            next_state = DECODE_ADDRESS;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= DECODE_ADDRESS;
            port  <= 2'd0;
        end else begin
            state <= next_state;
            port  <= next_port;
        end
    end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    // A soft reset on the expiry edge is a plain abort, not a timeout drop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (state != WAIT_TILL_EMPTY)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 8'd1;
            drop_q <= expire && !port_empty && !port_soft_reset;
        end
    end

    assign bus.drop_pkt = drop_q;
`else
    assign bus.drop_pkt = 1'b0;
`endif

    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.busy          = 1'b1;
        case (state)
            DECODE_ADDRESS: begin
                bus.detect_add = 1'b1;
                bus.busy       = 1'b0;
            end
            LOAD_FIRST_DATA: bus.lfd_state = 1'b1;
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b0;
            end
            FIFO_FULL_STATE: bus.full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_PARITY: bus.write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: bus.rst_int_reg = 1'b1;
            WAIT_TILL_EMPTY: bus.busy = 1'b1;
            default: begin
                bus.detect_add = 1'b1;
                bus.busy       = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32, cycles allowed in WAIT_TILL_EMPTY before abort (timeout build only, range 2..255).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: pkt_valid  in  1  packet byte valid from source.
REQ-005 SHALL have ports: data_in  in  2  address field (header bits [1:0]); 2'b11 invalid.
REQ-006 SHALL have ports: fifo_full  in  1  selected output FIFO full.
REQ-007 SHALL have ports: fifo_empty_0, fifo_empty_1, fifo_empty_2  in  1 each  output FIFO empty flags.
REQ-008 SHALL have ports: soft_reset_0, soft_reset_1, soft_reset_2  in  1 each  per-port soft reset.
REQ-009 SHALL have ports: parity_done, low_pkt_valid  in  1 each  status from register block.
REQ-010 SHALL have ports: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  state decodes to register block.
REQ-011 SHALL have ports: write_enb_reg  out  1  FIFO write enable; busy  out  1  stall source; drop_pkt  out  1  timeout abort pulse.

Function
REQ-012 SHALL implement a Moore FSM with states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY; outputs decoded from current state only.
REQ-013 SHALL, in DECODE_ADDRESS with pkt_valid and data_in==N (N in 0..2): go LOAD_FIRST_DATA if fifo_empty_N, else WAIT_TILL_EMPTY; latch N into an internal 2-bit port register on that edge.
REQ-014 SHALL remain in DECODE_ADDRESS when pkt_valid=0 or data_in==2'b11 (packet ignored, port register unchanged).
REQ-015 SHALL transit LOAD_FIRST_DATA -> LOAD_DATA unconditionally after one cycle.
REQ-016 SHALL, in LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay (fifo_full has priority).
REQ-017 SHALL stay in FIFO_FULL_STATE while fifo_full; !fifo_full -> LOAD_AFTER_FULL.
REQ-018 SHALL, in LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-019 SHALL transit LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-020 SHALL, in CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-021 SHALL, in WAIT_TILL_EMPTY: fifo_empty of latched port -> LOAD_FIRST_DATA; else stay.
REQ-022 SHALL, in any state other than DECODE_ADDRESS, go DECODE_ADDRESS on the next edge when soft_reset of the latched port is 1; this overrides every other transition; soft resets of other ports are ignored.
REQ-023 SHALL drive detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg high exactly in DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, FIFO_FULL_STATE, CHECK_PARITY_ERROR respectively; at most one high at any time.
REQ-024 SHALL drive write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; else 0.
REQ-025 SHALL drive busy=0 in DECODE_ADDRESS and LOAD_DATA; busy=1 in all other states.
REQ-026 SHALL decode unreachable state encodings as DECODE_ADDRESS on the next edge.

Reset
REQ-027 SHALL, on rstn=0, immediately force state DECODE_ADDRESS, port register 0, timeout counter 0, drop_pkt 0; hence detect_add=1, all other outputs 0.
REQ-028 SHALL resume normal transitions on the first rising clk edge after rstn deasserts; reset mid-packet discards the packet.

Configuration
REQ-029 SHALL, with macro ROUTER_FSM_WAIT_TIMEOUT_EN defined, count cycles spent in WAIT_TILL_EMPTY (counter cleared on entry); if TIMEOUT_CYCLES cycles elapse without the latched FIFO emptying, go DECODE_ADDRESS and pulse drop_pkt high for exactly one cycle (the first cycle in DECODE_ADDRESS); FIFO-empty on the same edge as expiry wins (go LOAD_FIRST_DATA, no pulse).
REQ-030 SHALL, without ROUTER_FSM_WAIT_TIMEOUT_EN, omit the counter, tie drop_pkt to 0, and wait in WAIT_TILL_EMPTY indefinitely.

Verification
REQ-031 Normal packet: header addr 1, fifo_empty_1=1, 4 payload bytes then pkt_valid=0 -> states DA,LFD,LD x4,LP,CPE,DA; write_enb_reg high 5 cycles (4 payload + parity); busy low only in DA/LD.
REQ-032 Full stall: fifo_full=1 for 3 cycles during LD -> FFS for 3 cycles, then LAF; with parity_done=0, low_pkt_valid=0 -> back to LD.
REQ-033 Busy port: header addr 2, fifo_empty_2=0 for 10 cycles -> WAIT_TILL_EMPTY 10 cycles, then LFD; addr 2'b11 with pkt_valid -> stays DA, detect_add stays 1.
REQ-034 Soft reset: latched port 0, soft_reset_1=1 in LD -> no effect; soft_reset_0=1 in FFS -> DA next edge.
REQ-035 Async reset: rstn low mid-LD between clock edges -> detect_add=1, ld_state=0 before next edge.
REQ-036 Timeout (macro defined, TIMEOUT_CYCLES=8): fifo_empty_0 stuck 0 -> exactly 8 cycles in WAIT_TILL_EMPTY, then DA with drop_pkt one-cycle pulse; macro undefined -> no exit, drop_pkt=0.
